// File: rtl/scr_det_pkg.sv
// Shared types and defaults for the multi-channel SCR fault detector.
//   scr_state_e : per-channel window state
//   DEF_*       : default timing (50 MHz clock) and sizing values
//   cnt_w_ok()  : elaboration-time check that the window counter cannot wrap
package scr_det_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_BOD_WIN = 3'd1,
    ST_BLANK   = 3'd2,
    ST_BD_WIN  = 3'd3,
    ST_TAIL    = 3'd4
  } scr_state_e;

  localparam int DEF_NUM_CH   = 2;
  localparam int DEF_CNT_W    = 21;
  localparam int DEF_T_BOD    = 25000;   // 500 us
  localparam int DEF_T_BLANK  = 42400;   // 848 us
  localparam int DEF_T_BD     = 900000;  // 18 ms
  localparam int DEF_T_TAIL   = 5;
  localparam int DEF_FILT_LEN = 8;

  // The counter peaks at t_bd + t_tail; it must stay below 2**cnt_w.
  function automatic bit cnt_w_ok(input int cnt_w, input int t_bd, input int t_tail);
    if (cnt_w >= 31) return 1'b1;
    return (t_bd + t_tail) < (1 << cnt_w);
  endfunction

endpackage

// File: rtl/scr_fault_detector_mc_if.sv
// Bus between the trigger/sense front end and the detector.
//   i_trig          : per-channel trigger pulses (rising edge starts a channel)
//   i_signal        : raw optical sense input
//   i_signal_forbid : 1 forbids pulsing, forces all channels idle
//   o_bod, o_bd_n   : per-channel result of the last completed cycle
//   o_done          : per-channel one-clock strobe
//   dbg_state       : per-channel FSM state, for observation only
// Handshake: there is no back-pressure. o_done[k] is a one-clock valid strobe;
// o_bod[k]/o_bd_n[k] change on the same edge and hold until the next strobe,
// forbid or reset, so a consumer may sample them on o_done[k] or at any time.
interface scr_fault_detector_mc_if #(
  parameter int NUM_CH = 2
);
  import scr_det_pkg::*;

  logic [NUM_CH-1:0]             i_trig;
  logic                          i_signal;
  logic                          i_signal_forbid;
  logic [NUM_CH-1:0]             o_bod;
  logic [NUM_CH-1:0]             o_bd_n;
  logic [NUM_CH-1:0]             o_done;
  scr_state_e [NUM_CH-1:0]       dbg_state;

  modport master (
    output i_trig, i_signal, i_signal_forbid,
    input  o_bod, o_bd_n, o_done, dbg_state
  );

  modport slave (
    input  i_trig, i_signal, i_signal_forbid,
    output o_bod, o_bd_n, o_done, dbg_state
  );

endinterface

// File: rtl/scr_sense_filter.sv
// Debounce for the raw sense input. The output follows the input only after
// the input has differed from the output for FILT_LEN consecutive clocks.
//   clk, rst : clock, synchronous active-high reset (output and counter to 0)
//   in       : raw input
//   out      : filtered output
module scr_sense_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int FW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
  localparam logic [FW-1:0] LAST = FW'(FILT_LEN - 1);

  logic [FW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= 1'b0;
      cnt <= '0;
    end else if (in == out) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      // FILT_LEN-th consecutive differing sample: accept the new level
      out <= in;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scr_fault_detector_mc.sv
// Multi-channel SCR breakdown / BOD detector. NUM_CH trigger channels share
// one filtered optical sense input. After each trigger a channel walks
// BOD_WIN -> BLANK -> BD_WIN, reports BOD (early sense edge) and breakdown
// (sense edge in BD_WIN) with a one-clock o_done, then idles for T_TAIL clocks.
//   i_clk_50m : clock
//   i_rst     : synchronous active-high reset
//   bus       : trigger, sense, forbid inputs; bod, bd_n, done, debug outputs
module scr_fault_detector_mc
  import scr_det_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int T_BOD    = DEF_T_BOD,
  parameter int T_BLANK  = DEF_T_BLANK,
  parameter int T_BD     = DEF_T_BD,
  parameter int T_TAIL   = DEF_T_TAIL,
  parameter int FILT_LEN = DEF_FILT_LEN
) (
  input logic                    i_clk_50m,
  input logic                    i_rst,
  scr_fault_detector_mc_if.slave bus
);

  if (!cnt_w_ok(CNT_W, T_BD, T_TAIL)) begin : g_cnt_w_check
    $error("scr_fault_detector_mc: CNT_W too small for T_BD + T_TAIL");
  end

  localparam logic [CNT_W-1:0] C_BOD   = CNT_W'(T_BOD);
  localparam logic [CNT_W-1:0] C_BLANK = CNT_W'(T_BLANK);
  localparam logic [CNT_W-1:0] C_BD    = CNT_W'(T_BD);
  localparam logic [CNT_W-1:0] C_TAIL0 = CNT_W'(T_BD + 1);
  localparam logic [CNT_W-1:0] C_END   = CNT_W'(T_BD + T_TAIL);

  logic              f_sig;
  logic              f_sig_q;
  logic              sedge;
  logic [NUM_CH-1:0] trig_q;
  logic [NUM_CH-1:0] tedge;
  logic [NUM_CH-1:0] bod_v;
  logic [NUM_CH-1:0] bd_n_v;
  logic [NUM_CH-1:0] done_v;

  scr_sense_filter #(.FILT_LEN(FILT_LEN)) u_filt (
    .clk (i_clk_50m),
    .rst (i_rst),
    .in  (bus.i_signal),
    .out (f_sig)
  );

  // Edge registers sample even during forbid so release cannot fake an edge.
  always_ff @(posedge i_clk_50m) begin
    if (i_rst) begin
      f_sig_q <= 1'b0;
      trig_q  <= '0;
    end else begin
      f_sig_q <= f_sig;
      trig_q  <= bus.i_trig;
    end
  end

  assign sedge = f_sig & ~f_sig_q;
  assign tedge = bus.i_trig & ~trig_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    scr_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             bod_seen;
    logic             bd_seen;
    logic             bod_r;
    logic             bd_n_r;
    logic             done_r;
    logic             abort;

    // Any other channel firing cuts this channel's breakdown window short.
    assign abort = |(tedge & ~(NUM_CH'(1) << k));

    always_ff @(posedge i_clk_50m) begin
      if (i_rst) begin
        state    <= ST_IDLE;
        cnt      <= '0;
        bod_seen <= 1'b0;
        bd_seen  <= 1'b0;
        bod_r    <= 1'b0;
        bd_n_r   <= 1'b1;
        done_r   <= 1'b0;
      end else if (bus.i_signal_forbid) begin
        state  <= ST_IDLE;
        cnt    <= '0;
        bod_r  <= 1'b1;
        bd_n_r <= 1'b1;
        done_r <= 1'b0;
      end else begin
        done_r <= 1'b0;
        if (tedge[k]) begin
          // Start or restart; a partial cycle is dropped without a report.
          state    <= ST_BOD_WIN;
          cnt      <= CNT_W'(1);
          bod_seen <= 1'b0;
          bd_seen  <= 1'b0;
        end else begin
          case (state)
            ST_IDLE: cnt <= '0;
            ST_BOD_WIN: begin
              cnt <= cnt + 1'b1;
              if (sedge) bod_seen <= 1'b1;
              if (cnt == C_BOD) state <= ST_BLANK;
            end
            ST_BLANK: begin
              cnt <= cnt + 1'b1;
              if (cnt == C_BLANK) state <= ST_BD_WIN;
            end
            ST_BD_WIN: begin
              if (cnt == C_BD || abort) begin
                // A sense edge on the closing cycle still counts.
                bod_r  <= bod_seen;
                bd_n_r <= ~(bd_seen | sedge);
                done_r <= 1'b1;
                state  <= ST_TAIL;
                cnt    <= C_TAIL0;  // aligns the tail after an early abort
              end else begin
                cnt <= cnt + 1'b1;
                if (sedge) bd_seen <= 1'b1;
              end
            end
            ST_TAIL: begin
              if (cnt == C_END) begin
                state <= ST_IDLE;
                cnt   <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            default: begin
              state <= ST_IDLE;
              cnt   <= '0;
            end
          endcase
        end
      end
    end

    assign bod_v[k]         = bod_r;
    assign bd_n_v[k]        = bd_n_r;
    assign done_v[k]        = done_r;
    assign bus.dbg_state[k] = state;
  end

  assign bus.o_bod  = bod_v;
  assign bus.o_bd_n = bd_n_v;
  assign bus.o_done = done_v;

endmodule

// File: tb/tb_scr_fault_detector_mc.sv
module tb_scr_fault_detector_mc;
  import scr_det_pkg::*;

  localparam int NUM_CH   = 3;
  localparam int CNT_W    = 21;
  localparam int T_BOD    = 10;
  localparam int T_BLANK  = 20;
  localparam int T_BD     = 100;
  localparam int T_TAIL   = 5;
  localparam int FILT_LEN = 2;
  localparam int RUN_LEN  = 170;

  // ---------------- clock / reset ----------------
  logic i_clk_50m = 1'b0;
  logic i_rst;
  always #10 i_clk_50m = ~i_clk_50m;

  scr_fault_detector_mc_if #(.NUM_CH(NUM_CH)) bus ();

  scr_fault_detector_mc #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .T_BOD(T_BOD), .T_BLANK(T_BLANK),
    .T_BD(T_BD), .T_TAIL(T_TAIL), .FILT_LEN(FILT_LEN)
  ) dut (
    .i_clk_50m (i_clk_50m),
    .i_rst     (i_rst),
    .bus       (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each channel is described by its age since the trigger (0 = not in a
  // measurement). Age ranges decide which window a sense edge falls in.
  logic [NUM_CH-1:0] m_trig_q;
  logic              m_fsig, m_fsig_q;
  logic              sig_hist[$];
  int                m_age[NUM_CH];
  logic              m_bod_seen[NUM_CH];
  logic              m_bd_seen[NUM_CH];
  logic [NUM_CH-1:0] m_bod, m_bd_n, m_done;

  task automatic model_edge(input logic [NUM_CH-1:0] trig, input logic sig,
                            input logic forbid, input logic rst);
    logic [NUM_CH-1:0] tedge;
    logic sedge, same, abort;
    tedge = trig & ~m_trig_q;
    sedge = m_fsig & ~m_fsig_q;
    if (rst) begin
      m_trig_q = '0; m_fsig = 1'b0; m_fsig_q = 1'b0;
      sig_hist.delete();
      for (int k = 0; k < NUM_CH; k++) begin
        m_age[k] = 0; m_bod_seen[k] = 1'b0; m_bd_seen[k] = 1'b0;
      end
      m_bod = '0; m_bd_n = '1; m_done = '0;
      return;
    end
    m_trig_q = trig;
    m_fsig_q = m_fsig;
    sig_hist.push_back(sig);
    if (sig_hist.size() > FILT_LEN) void'(sig_hist.pop_front());
    if (sig_hist.size() == FILT_LEN) begin
      same = 1'b1;
      foreach (sig_hist[i]) if (sig_hist[i] != sig) same = 1'b0;
      if (same) m_fsig = sig;
    end
    if (forbid) begin
      for (int k = 0; k < NUM_CH; k++) m_age[k] = 0;
      m_bod = '1; m_bd_n = '1; m_done = '0;
      return;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      m_done[k] = 1'b0;
      abort = 1'b0;
      for (int j = 0; j < NUM_CH; j++) if (j != k && tedge[j]) abort = 1'b1;
      if (tedge[k]) begin
        m_age[k] = 1; m_bod_seen[k] = 1'b0; m_bd_seen[k] = 1'b0;
      end else if (m_age[k] >= 1 && m_age[k] <= T_BD) begin
        if (sedge && m_age[k] <= T_BOD)  m_bod_seen[k] = 1'b1;
        if (sedge && m_age[k] > T_BLANK) m_bd_seen[k] = 1'b1;
        if (m_age[k] > T_BLANK && (m_age[k] == T_BD || abort)) begin
          m_bod[k]  = m_bod_seen[k];
          m_bd_n[k] = ~m_bd_seen[k];
          m_done[k] = 1'b1;
          m_age[k]  = 0;  // the tail behaves like idle from outside
        end else begin
          m_age[k]++;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  // Inputs are driven at the falling edge; outputs are compared at the next
  // falling edge, after the rising edge that consumed the inputs.
  task automatic step(input logic [NUM_CH-1:0] trig, input logic sig,
                      input logic forbid, input logic rst);
    bus.i_trig = trig; bus.i_signal = sig; bus.i_signal_forbid = forbid; i_rst = rst;
    model_edge(trig, sig, forbid, rst);
    @(posedge i_clk_50m);
    @(negedge i_clk_50m);
    check("cycle_outputs", 32'({bus.o_bod, bus.o_bd_n, bus.o_done}),
          32'({m_bod, m_bd_n, m_done}));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string name;
    int    ch_a;      // triggered at step 0
    int    ch_b;      // second trigger channel (-1 none)
    int    b_at;      // step of the second trigger
    int    s_at;      // first step of the raw sense pulse (-1 none)
    int    s_len;     // raw sense pulse width in clocks
    int    watch_ch;
    int    exp_at;    // step at which o_done[watch_ch] is observed
    logic  exp_bod;
    logic  exp_bd_n;
  } vec_t;

  function automatic vec_t mk(input string n, input int a, input int b, input int bat,
                              input int s, input int sl, input int w, input int at,
                              input logic eb, input logic ebd);
    vec_t r;
    r.name = n; r.ch_a = a; r.ch_b = b; r.b_at = bat; r.s_at = s; r.s_len = sl;
    r.watch_ch = w; r.exp_at = at; r.exp_bod = eb; r.exp_bd_n = ebd;
    return r;
  endfunction

  // Raw sense held from step s reaches the channel as an edge at cnt = s + FILT_LEN.
  task automatic run_vec(input vec_t r);
    logic [NUM_CH-1:0] t;
    logic s;
    int done_at, done_cnt;
    logic got_bod, got_bd_n;
    done_at = -1; done_cnt = 0; got_bod = 1'bx; got_bd_n = 1'bx;
    for (int i = 0; i < RUN_LEN; i++) begin
      t = '0;
      if (i == 0) t[r.ch_a] = 1'b1;
      if (r.ch_b >= 0 && i == r.b_at) t[r.ch_b] = 1'b1;
      s = (r.s_at >= 0 && i >= r.s_at && i < r.s_at + r.s_len);
      step(t, s, 1'b0, 1'b0);
      if (bus.o_done[r.watch_ch]) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at  = i;
          got_bod  = bus.o_bod[r.watch_ch];
          got_bd_n = bus.o_bd_n[r.watch_ch];
        end
      end
    end
    check({r.name, "_done_at"}, 32'(done_at), 32'(r.exp_at));
    check({r.name, "_done_count"}, 32'(done_cnt), 32'd1);
    check({r.name, "_bod"}, 32'(got_bod), 32'(r.exp_bod));
    check({r.name, "_bd_n"}, 32'(got_bd_n), 32'(r.exp_bd_n));
    repeat (20) step('0, 1'b0, 1'b0, 1'b0);
  endtask

  vec_t vecs[$];

  initial begin
    int done_any;
    logic [NUM_CH-1:0] rt;
    logic rs;
    int fb;

    vecs.push_back(mk("bod_early",       0, -1,  0,  3, 4, 0, 100, 1'b1, 1'b1));
    vecs.push_back(mk("bd_mid",          1, -1,  0, 48, 4, 1, 100, 1'b0, 1'b0));
    vecs.push_back(mk("blank_ignored",   1, -1,  0, 13, 4, 1, 100, 1'b0, 1'b1));
    vecs.push_back(mk("bod_last",        0, -1,  0,  8, 4, 0, 100, 1'b1, 1'b1));
    vecs.push_back(mk("blank_first",     2, -1,  0,  9, 4, 2, 100, 1'b0, 1'b1));
    vecs.push_back(mk("blank_last",      2, -1,  0, 18, 4, 2, 100, 1'b0, 1'b1));
    vecs.push_back(mk("bd_first",        0, -1,  0, 19, 4, 0, 100, 1'b0, 1'b0));
    vecs.push_back(mk("bd_last",         1, -1,  0, 98, 4, 1, 100, 1'b0, 1'b0));
    vecs.push_back(mk("no_sense",        2, -1,  0, -1, 0, 2, 100, 1'b0, 1'b1));
    vecs.push_back(mk("glitch_1clk",     0, -1,  0,  3, 1, 0, 100, 1'b0, 1'b1));
    vecs.push_back(mk("pulse_2clk",      0, -1,  0,  3, 2, 0, 100, 1'b1, 1'b1));
    vecs.push_back(mk("abort_ch0",       0,  2, 60, -1, 0, 0,  60, 1'b0, 1'b1));
    vecs.push_back(mk("abort_ch2_runs",  0,  2, 60, -1, 0, 2, 160, 1'b0, 1'b1));
    vecs.push_back(mk("abort_with_edge", 0,  1, 60, 58, 4, 0,  60, 1'b0, 1'b0));
    vecs.push_back(mk("retrigger",       0,  0, 50,  3, 4, 0, 150, 1'b0, 1'b1));
    vecs.push_back(mk("same_cycle_trig", 0,  1,  0, -1, 0, 1, 100, 1'b0, 1'b1));
    vecs.push_back(mk("blank_no_abort",  0,  1, 15, -1, 0, 0, 100, 1'b0, 1'b1));

    // reset state
    bus.i_trig = '0; bus.i_signal = 1'b0; bus.i_signal_forbid = 1'b0; i_rst = 1'b1;
    @(negedge i_clk_50m);
    repeat (3) step('0, 1'b0, 1'b0, 1'b1);
    check("reset_bod", 32'(bus.o_bod), 32'd0);
    check("reset_bd_n", 32'(bus.o_bd_n), 32'h7);
    check("reset_done", 32'(bus.o_done), 32'd0);
    for (int k = 0; k < NUM_CH; k++)
      check("reset_state_idle", 32'(bus.dbg_state[k]), 32'(ST_IDLE));
    repeat (5) step('0, 1'b0, 1'b0, 1'b0);

    foreach (vecs[v]) run_vec(vecs[v]);

    // forbid mid-BD_WIN; ch1 trigger rises under forbid and stays high past release
    done_any = 0;
    for (int i = 0; i < RUN_LEN; i++) begin
      rt = '0;
      if (i == 0) rt[0] = 1'b1;
      if (i >= 51 && i < 60) rt[1] = 1'b1;
      step(rt, (i >= 40 && i < 44), (i >= 50 && i < 55), 1'b0);
      if (bus.o_done != '0) done_any++;
      if (i == 52) begin
        check("forbid_bod", 32'(bus.o_bod), 32'h7);
        check("forbid_bd_n", 32'(bus.o_bd_n), 32'h7);
        check("forbid_state_idle", 32'(bus.dbg_state[0]), 32'(ST_IDLE));
      end
      if (i == 60) begin
        check("forbid_hold_bod", 32'(bus.o_bod), 32'h7);
        check("forbid_hold_bd_n", 32'(bus.o_bd_n), 32'h7);
      end
    end
    check("forbid_no_done", 32'(done_any), 32'd0);
    repeat (10) step('0, 1'b0, 1'b0, 1'b0);

    // reset mid-window, then a clean scenario-1 run
    done_any = 0;
    for (int i = 0; i < RUN_LEN; i++) begin
      rt = '0;
      if (i == 0) rt[1] = 1'b1;
      step(rt, (i >= 3 && i < 7), 1'b0, (i == 40 || i == 41));
      if (bus.o_done != '0) done_any++;
      if (i == 41) begin
        check("midrst_bod", 32'(bus.o_bod), 32'd0);
        check("midrst_bd_n", 32'(bus.o_bd_n), 32'h7);
        check("midrst_done", 32'(bus.o_done), 32'd0);
      end
    end
    check("midrst_no_done", 32'(done_any), 32'd0);
    run_vec(mk("after_reset", 0, -1, 0, 3, 4, 0, 100, 1'b1, 1'b1));

    // randomized traffic against the model
    rt = '0; rs = 1'b0; fb = 0;
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < NUM_CH; k++)
        if ($urandom_range(0, 99) == 0) rt[k] = ~rt[k];
      if ($urandom_range(0, 5) == 0) rs = ~rs;
      if (fb > 0) fb--;
      else if ($urandom_range(0, 499) == 0) fb = int'($urandom_range(1, 6));
      step(rt, rs, (fb > 0), ($urandom_range(0, 1999) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
